mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter NrTid, default 4: read transaction IDs in the pool; TidWidth = clog2(NrTid).
REQ-002 Parameter MaxStores, default 7: maximum outstanding stores awaiting ack.
REQ-003 Parameters AddrWidth and LineWidth, defaults 64 and 128: address width and read-data width.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 ifill_req_i/ifill_gnt_o  in/out  1/1  icache fill request and grant.
REQ-007 ifill_addr_i  in  AddrWidth  icache fill address.
REQ-008 ld_req_i/ld_gnt_o  in/out  1/1  dcache load request and grant.
REQ-009 ld_addr_i, ld_size_i  in  AddrWidth, 2  load address and size.
REQ-010 st_req_i/st_gnt_o  in/out  1/1  write-buffer store request and grant.
REQ-011 st_addr_i, st_data_i, st_be_i  in  AddrWidth, 64, 8  store address, data, byte enables.
REQ-012 drain_i  in  1  fence: block new grants.
REQ-013 mem_req_o, mem_gnt_i  out/in  1/1  memory-port request and grant.
REQ-014 mem_type_o  out  2  0 = ifill, 1 = load, 2 = store.
REQ-015 mem_addr_o, mem_size_o, mem_data_o, mem_be_o, mem_tid_o  out  AddrWidth, 2, 64, 8, TidWidth  muxed winner payload.
REQ-016 mem_rvalid_i, mem_rstore_i, mem_rtid_i, mem_rdata_i  in  1, 1, TidWidth, LineWidth  response; mem_rstore_i=1 means store ack.
REQ-017 ifill_rvalid_o, ld_rvalid_o, st_ack_o  out  1 each  routed response strobes.
REQ-018 rdata_o  out  LineWidth  mem_rdata_i passed through combinationally.
REQ-019 idle_o, err_o  out  1, 1  nothing outstanding; sticky spurious-response flag.

Function
REQ-020 Requester eligibility: ifill/ld need req and at least one free TID; st needs req and store count < MaxStores; none eligible while drain_i=1.
REQ-021 Round-robin order ifill -> ld -> st; search starts at priority pointer; first eligible wins.
REQ-022 mem_req_o = any eligible; payload and mem_type_o from winner, combinational same cycle.
REQ-023 Handshake = mem_req_o & mem_gnt_i; winner's gnt_o = handshake; other gnt_o = 0.
REQ-024 On handshake, pointer moves to index after winner (st wraps to ifill); otherwise unchanged.
REQ-025 Read TID = lowest-index TID free at cycle start, driven on mem_tid_o; on handshake marked busy with owner (ifill/ld).
REQ-026 Store: mem_tid_o = 0, no TID consumed; store count +1 on handshake.
REQ-027 Read response (rvalid=1, rstore=0) to busy TID: owner's rvalid_o pulses same cycle (0 latency), TID freed at next edge.
REQ-028 Store ack (rvalid=1, rstore=1): st_ack_o pulses same cycle; count -1.
REQ-029 Simultaneous store handshake and store ack: count unchanged.
REQ-030 TID freed in a cycle is not reallocatable until next cycle; pool-full frees no grant that cycle.
REQ-031 Read response to free TID, or store ack at count 0: no strobe, no state change, err_o set until reset.
REQ-032 idle_o = 1 iff no busy TID and store count = 0, registered-state based.
REQ-033 Requesters hold req and payload until gnt; arbiter does not depend on deassert-before-grant.

Reset
REQ-034 rst_ni low asynchronously clears all TIDs to free, store count 0, pointer to ifill, err_o 0; all gnt/strobe outputs 0, idle_o 1.
REQ-035 Reset mid-transaction abandons outstanding state; responses after reset release count as spurious (REQ-031).

Verification
REQ-036 ifill, ld, st requests together, mem_gnt_i=1 for 3 cycles -> grants ifill, ld, st in order; mem_tid_o 0, 1, 0; store count 1.
REQ-037 4 loads granted, no responses -> 5th load not requested (mem_req_o=0); response on TID 2 -> ld_rvalid_o pulse; next cycle 5th load gets TID 2.
REQ-038 7 stores granted, no acks -> 8th blocked; store handshake plus ack same cycle at count 6 -> count stays 6.
REQ-039 Response to free TID 3 -> no rvalid strobe, err_o=1 held until reset.
REQ-040 drain_i=1 with pending requests -> no grants; idle_o rises after last response; drain_i=0 resumes round-robin from saved pointer.
REQ-041 Assert rst_ni=0 with 2 TIDs busy and count 3 -> idle_o=1 and all gnt 0 immediately, before next clock edge.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Memory-port arbiter: round-robin between icache fills, dcache loads and store
// drains, with a read-TID pool, an outstanding-store counter and response routing.
module mem_req_arbiter #(
  parameter int NrTid     = 4,
  parameter int MaxStores = 7,
  parameter int AddrWidth = 64,
  parameter int LineWidth = 128,
  localparam int TidWidth = (NrTid > 1) ? $clog2(NrTid) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ifill_req_i,
  output logic                 ifill_gnt_o,
  input  logic [AddrWidth-1:0] ifill_addr_i,
  input  logic                 ld_req_i,
  output logic                 ld_gnt_o,
  input  logic [AddrWidth-1:0] ld_addr_i,
  input  logic [1:0]           ld_size_i,
  input  logic                 st_req_i,
  output logic                 st_gnt_o,
  input  logic [AddrWidth-1:0] st_addr_i,
  input  logic [63:0]          st_data_i,
  input  logic [7:0]           st_be_i,
  input  logic                 drain_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [1:0]           mem_type_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [1:0]           mem_size_o,
  output logic [63:0]          mem_data_o,
  output logic [7:0]           mem_be_o,
  output logic [TidWidth-1:0]  mem_tid_o,
  input  logic                 mem_rvalid_i,
  input  logic                 mem_rstore_i,
  input  logic [TidWidth-1:0]  mem_rtid_i,
  input  logic [LineWidth-1:0] mem_rdata_i,
  output logic                 ifill_rvalid_o,
  output logic                 ld_rvalid_o,
  output logic                 st_ack_o,
  output logic [LineWidth-1:0] rdata_o,
  output logic                 idle_o,
  output logic                 err_o
);

  localparam int CntWidth = $clog2(MaxStores + 1);
  localparam logic [1:0] TypeIfill = 2'd0;
  localparam logic [1:0] TypeLd    = 2'd1;
  localparam logic [1:0] TypeSt    = 2'd2;

  logic [NrTid-1:0]    tid_busy_reg, tid_busy_next;
  logic [NrTid-1:0]    tid_owner_ld_reg, tid_owner_ld_next;  // 1 = load owns the TID, 0 = ifill
  logic [CntWidth-1:0] st_cnt_reg, st_cnt_next;
  logic [1:0]          ptr_reg, ptr_next;
  logic                err_reg, err_next;

  logic                tid_avail;
  logic [TidWidth-1:0] free_tid;
  logic [2:0]          elig;
  logic [1:0]          winner;
  logic                found;
  logic [2:0]          idx;
  logic                hs, st_hs, rd_hs;
  logic                rtid_valid, rtid_busy, rd_ok, spurious;

  always_comb begin
    tid_avail = 1'b0;
    free_tid  = '0;
    for (int i = NrTid - 1; i >= 0; i--) begin
      if (!tid_busy_reg[i]) begin
        tid_avail = 1'b1;
        free_tid  = TidWidth'(i);
      end
    end
  end

  // Gating with rst_ni keeps every grant low for the whole reset window.
  assign elig[0] = rst_ni & ~drain_i & ifill_req_i & tid_avail;
  assign elig[1] = rst_ni & ~drain_i & ld_req_i & tid_avail;
  assign elig[2] = rst_ni & ~drain_i & st_req_i & (st_cnt_reg < CntWidth'(MaxStores));

  always_comb begin
    winner = ptr_reg;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 3; k++) begin
      idx = {1'b0, ptr_reg} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && elig[idx]) begin
        winner = idx[1:0];
        found  = 1'b1;
      end
    end
  end

  assign mem_req_o   = |elig;
  assign hs          = mem_req_o & mem_gnt_i;
  assign st_hs       = hs & (winner == TypeSt);
  assign rd_hs       = hs & (winner != TypeSt);
  assign ifill_gnt_o = hs & (winner == TypeIfill);
  assign ld_gnt_o    = hs & (winner == TypeLd);
  assign st_gnt_o    = st_hs;

  always_comb begin
    mem_type_o = winner;
    mem_addr_o = ifill_addr_i;
    mem_size_o = 2'd3;
    mem_data_o = '0;
    mem_be_o   = '0;
    mem_tid_o  = free_tid;
    case (winner)
      TypeLd: begin
        mem_addr_o = ld_addr_i;
        mem_size_o = ld_size_i;
      end
      TypeSt: begin
        mem_addr_o = st_addr_i;
        mem_data_o = st_data_i;
        mem_be_o   = st_be_i;
        mem_tid_o  = '0;
      end
      default: ;
    endcase
  end

  assign rtid_valid     = int'(mem_rtid_i) < NrTid;
  assign rtid_busy      = rtid_valid && tid_busy_reg[mem_rtid_i];
  assign rd_ok          = rst_ni & mem_rvalid_i & ~mem_rstore_i & rtid_busy;
  assign ifill_rvalid_o = rd_ok & ~tid_owner_ld_reg[mem_rtid_i];
  assign ld_rvalid_o    = rd_ok & tid_owner_ld_reg[mem_rtid_i];
  assign st_ack_o       = rst_ni & mem_rvalid_i & mem_rstore_i & (st_cnt_reg != '0);
  assign spurious       = mem_rvalid_i & (mem_rstore_i ? (st_cnt_reg == '0) : ~rtid_busy);
  assign rdata_o        = mem_rdata_i;

  // Allocation uses a TID free at cycle start, so it never collides with a release.
  for (genvar gi = 0; gi < NrTid; gi++) begin : g_tid
    logic alloc, free_evt;
    assign alloc    = rd_hs & (free_tid == TidWidth'(gi));
    assign free_evt = rd_ok & (mem_rtid_i == TidWidth'(gi));
    assign tid_busy_next[gi]     = alloc | (tid_busy_reg[gi] & ~free_evt);
    assign tid_owner_ld_next[gi] = alloc ? (winner == TypeLd) : tid_owner_ld_reg[gi];
  end

  always_comb begin
    st_cnt_next = st_cnt_reg;
    if (st_hs && !st_ack_o)      st_cnt_next = st_cnt_reg + 1'b1;
    else if (!st_hs && st_ack_o) st_cnt_next = st_cnt_reg - 1'b1;
  end

  assign ptr_next = !hs ? ptr_reg : (winner == TypeSt) ? TypeIfill : winner + 2'd1;
  assign err_next = err_reg | spurious;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tid_busy_reg     <= '0;
      tid_owner_ld_reg <= '0;
      st_cnt_reg       <= '0;
      ptr_reg          <= TypeIfill;
      err_reg          <= 1'b0;
    end else begin
      tid_busy_reg     <= tid_busy_next;
      tid_owner_ld_reg <= tid_owner_ld_next;
      st_cnt_reg       <= st_cnt_next;
      ptr_reg          <= ptr_next;
      err_reg          <= err_next;
    end
  end

  assign idle_o = ~|tid_busy_reg & (st_cnt_reg == '0);
  assign err_o  = err_reg;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: expected grants and response strobes
// are queued when stimulus is driven and popped when the DUT output is sampled.
module tb_mem_req_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         ifill_req_i, ld_req_i, st_req_i, drain_i, mem_gnt_i;
  logic         ifill_gnt_o, ld_gnt_o, st_gnt_o, mem_req_o;
  logic [63:0]  ifill_addr_i, ld_addr_i, st_addr_i, st_data_i, mem_addr_o, mem_data_o;
  logic [1:0]   ld_size_i, mem_type_o, mem_size_o, mem_tid_o, mem_rtid_i;
  logic [7:0]   st_be_i, mem_be_o;
  logic         mem_rvalid_i, mem_rstore_i;
  logic [127:0] mem_rdata_i, rdata_o;
  logic         ifill_rvalid_o, ld_rvalid_o, st_ack_o, idle_o, err_o;

  typedef struct packed {
    logic [1:0]  typ;
    logic [1:0]  tid;
    logic [63:0] addr;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] rsp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk_i = ~clk_i;

  mem_req_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ifill_req_i(ifill_req_i), .ifill_gnt_o(ifill_gnt_o), .ifill_addr_i(ifill_addr_i),
    .ld_req_i(ld_req_i), .ld_gnt_o(ld_gnt_o), .ld_addr_i(ld_addr_i), .ld_size_i(ld_size_i),
    .st_req_i(st_req_i), .st_gnt_o(st_gnt_o), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .st_be_i(st_be_i), .drain_i(drain_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_type_o(mem_type_o),
    .mem_addr_o(mem_addr_o), .mem_size_o(mem_size_o), .mem_data_o(mem_data_o),
    .mem_be_o(mem_be_o), .mem_tid_o(mem_tid_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rstore_i(mem_rstore_i), .mem_rtid_i(mem_rtid_i),
    .mem_rdata_i(mem_rdata_i), .ifill_rvalid_o(ifill_rvalid_o), .ld_rvalid_o(ld_rvalid_o),
    .st_ack_o(st_ack_o), .rdata_o(rdata_o), .idle_o(idle_o), .err_o(err_o)
  );

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clr();
    ifill_req_i = 0; ld_req_i = 0; st_req_i = 0; drain_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 0; mem_rstore_i = 0; mem_rtid_i = '0;
  endtask

  // Stimulus only: drive a response and queue the strobes it must produce.
  task automatic drive_rsp(input logic store, input logic [1:0] tid, input logic [2:0] strobes);
    mem_rvalid_i = 1; mem_rstore_i = store; mem_rtid_i = tid;
    mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
    rsp_q.push_back(strobes);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_ni = 0;
    ifill_req_i = 1; ld_req_i = 1; st_req_i = 1; mem_gnt_i = 1;
    #1;
    n_tests++;
    if (idle_o !== 1'b1 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_state idle=%b err=%b required idle=1 err=0", idle_o, err_o);
    end
    n_tests++;
    if ({mem_req_o, ifill_gnt_o, ld_gnt_o, st_gnt_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_grants req/gnt=%b required 0000", {mem_req_o, ifill_gnt_o, ld_gnt_o, st_gnt_o});
    end
    clr();
    cyc();
    rst_ni = 1;
    cyc();
    e = '{2'd0, 2'd0, 64'h0};
    $display("[TB] reset released, tid=%0d", e.tid);
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [2:0] g, s;
    ifill_req_i = 1; ld_req_i = 1; st_req_i = 1; mem_gnt_i = 1;
    exp_q.push_back('{2'd0, 2'd0, 64'h1000});
    exp_q.push_back('{2'd1, 2'd1, 64'h2000});
    exp_q.push_back('{2'd2, 2'd0, 64'h3000});
    for (int i = 0; i < 3; i++) begin
      #1;
      e = exp_q.pop_front();
      g = 3'b100 >> e.typ;
      $display("[TB] rr grant type=%0d tid=%0d addr=%h", mem_type_o, mem_tid_o, mem_addr_o);
      n_tests++;
      if (mem_type_o !== e.typ || mem_tid_o !== e.tid || mem_addr_o !== e.addr) begin
        n_fail++; $display("FAIL rr_payload type/tid/addr=%0d/%0d/%h required %0d/%0d/%h",
                           mem_type_o, mem_tid_o, mem_addr_o, e.typ, e.tid, e.addr);
      end
      n_tests++;
      if ({ifill_gnt_o, ld_gnt_o, st_gnt_o} !== g) begin
        n_fail++; $display("FAIL rr_gnt gnt=%b required %b", {ifill_gnt_o, ld_gnt_o, st_gnt_o}, g);
      end
      cyc();
    end
    clr();
    #1;
    n_tests++;
    if (idle_o !== 1'b0) begin
      n_fail++; $display("FAIL rr_busy idle=%b required 0", idle_o);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive_rsp(0, 2'd0, 3'b100);
      else if (i == 1) drive_rsp(0, 2'd1, 3'b010);
      else drive_rsp(1, 2'd0, 3'b001);
      #1;
      s = rsp_q.pop_front();
      $display("[TB] rr response %0d strobes=%b", i, {ifill_rvalid_o, ld_rvalid_o, st_ack_o});
      n_tests++;
      if ({ifill_rvalid_o, ld_rvalid_o, st_ack_o} !== s || rdata_o !== mem_rdata_i) begin
        n_fail++; $display("FAIL rr_rsp strobes=%b required %b rdata=%h required %h",
                           {ifill_rvalid_o, ld_rvalid_o, st_ack_o}, s, rdata_o, mem_rdata_i);
      end
      cyc();
    end
    clr();
    #1;
    n_tests++;
    if (idle_o !== 1'b1) begin
      n_fail++; $display("FAIL rr_idle idle=%b required 1", idle_o);
    end
  endtask

  task automatic test_tid_exhaust();
    exp_t e;
    logic [2:0] s;
    cyc();
    ld_req_i = 1; ld_size_i = 2'd2; mem_gnt_i = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{2'd1, 2'(i), 64'h2000});
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        mem_rvalid_i = 0;
        exp_q.push_back('{2'd1, 2'd2, 64'h2000});
      end
      #1;
      e = exp_q.pop_front();
      $display("[TB] ld grant tid=%0d size=%0d", mem_tid_o, mem_size_o);
      n_tests++;
      if (ld_gnt_o !== 1'b1 || mem_type_o !== e.typ || mem_tid_o !== e.tid || mem_size_o !== 2'd2) begin
        n_fail++; $display("FAIL ld_grant gnt=%b type=%0d tid=%0d size=%0d required 1/%0d/%0d/2",
                           ld_gnt_o, mem_type_o, mem_tid_o, mem_size_o, e.typ, e.tid);
      end
      cyc();
      if (i == 3) begin
        #1;
        n_tests++;
        if (mem_req_o !== 1'b0 || ld_gnt_o !== 1'b0) begin
          n_fail++; $display("FAIL pool_full req=%b gnt=%b required 0/0", mem_req_o, ld_gnt_o);
        end
        drive_rsp(0, 2'd2, 3'b010);
        #1;
        s = rsp_q.pop_front();
        $display("[TB] ld response tid=2 strobes=%b", {ifill_rvalid_o, ld_rvalid_o, st_ack_o});
        n_tests++;
        if ({ifill_rvalid_o, ld_rvalid_o, st_ack_o} !== s || mem_req_o !== 1'b0) begin
          n_fail++; $display("FAIL pool_free strobes=%b req=%b required %b/0",
                             {ifill_rvalid_o, ld_rvalid_o, st_ack_o}, mem_req_o, s);
        end
        cyc();
      end
    end
    clr();
    for (int i = 0; i < 4; i++) begin
      drive_rsp(0, 2'(i), 3'b010);
      #1;
      s = rsp_q.pop_front();
      $display("[TB] ld response tid=%0d strobes=%b", i, {ifill_rvalid_o, ld_rvalid_o, st_ack_o});
      n_tests++;
      if ({ifill_rvalid_o, ld_rvalid_o, st_ack_o} !== s) begin
        n_fail++; $display("FAIL ld_rsp tid=%0d strobes=%b required %b", i, {ifill_rvalid_o, ld_rvalid_o, st_ack_o}, s);
      end
      cyc();
    end
    clr();
  endtask

  task automatic test_store_limit();
    exp_t e;
    logic [2:0] s;
    st_req_i = 1; mem_gnt_i = 1;
    for (int i = 0; i < 7; i++) begin
      st_data_i = {$urandom, $urandom}; st_be_i = 8'($urandom);
      exp_q.push_back('{2'd2, 2'd0, 64'h3000});
      #1;
      e = exp_q.pop_front();
      $display("[TB] st grant %0d data=%h be=%h", i, mem_data_o, mem_be_o);
      n_tests++;
      if (st_gnt_o !== 1'b1 || mem_type_o !== e.typ || mem_tid_o !== e.tid || mem_addr_o !== e.addr ||
          mem_data_o !== st_data_i || mem_be_o !== st_be_i) begin
        n_fail++; $display("FAIL st_grant gnt=%b type=%0d tid=%0d data=%h be=%h required 1/%0d/%0d/%h/%h",
                           st_gnt_o, mem_type_o, mem_tid_o, mem_data_o, mem_be_o, e.typ, e.tid, st_data_i, st_be_i);
      end
      cyc();
    end
    #1;
    n_tests++;
    if (mem_req_o !== 1'b0 || st_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL st_limit req=%b gnt=%b required 0/0", mem_req_o, st_gnt_o);
    end
    drive_rsp(1, 2'd0, 3'b001);
    #1;
    s = rsp_q.pop_front();
    n_tests++;
    if ({ifill_rvalid_o, ld_rvalid_o, st_ack_o} !== s || st_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL st_ack7 strobes=%b gnt=%b required %b/0", {ifill_rvalid_o, ld_rvalid_o, st_ack_o}, st_gnt_o, s);
    end
    cyc();
    // Count is 6: grant and ack together must leave it at 6.
    drive_rsp(1, 2'd0, 3'b001);
    #1;
    s = rsp_q.pop_front();
    $display("[TB] st grant+ack gnt=%b ack=%b", st_gnt_o, st_ack_o);
    n_tests++;
    if ({ifill_rvalid_o, ld_rvalid_o, st_ack_o} !== s || st_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL st_simul strobes=%b gnt=%b required %b/1", {ifill_rvalid_o, ld_rvalid_o, st_ack_o}, st_gnt_o, s);
    end
    cyc();
    mem_rvalid_i = 0;
    #1;
    n_tests++;
    if (st_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL st_count6 gnt=%b required 1", st_gnt_o);
    end
    cyc();
    #1;
    n_tests++;
    if (mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL st_count7 req=%b required 0", mem_req_o);
    end
    clr();
    for (int i = 0; i < 7; i++) begin
      drive_rsp(1, 2'd0, 3'b001);
      #1;
      s = rsp_q.pop_front();
      $display("[TB] st ack %0d strobes=%b", i, {ifill_rvalid_o, ld_rvalid_o, st_ack_o});
      n_tests++;
      if ({ifill_rvalid_o, ld_rvalid_o, st_ack_o} !== s) begin
        n_fail++; $display("FAIL st_drain ack %0d strobes=%b required %b", i, {ifill_rvalid_o, ld_rvalid_o, st_ack_o}, s);
      end
      cyc();
    end
    clr();
    #1;
    n_tests++;
    if (idle_o !== 1'b1 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL st_idle idle=%b err=%b required 1/0", idle_o, err_o);
    end
  endtask

  task automatic test_spurious();
    logic [2:0] s;
    drive_rsp(0, 2'd3, 3'b000);
    #1;
    s = rsp_q.pop_front();
    $display("[TB] spurious read tid=3 strobes=%b", {ifill_rvalid_o, ld_rvalid_o, st_ack_o});
    n_tests++;
    if ({ifill_rvalid_o, ld_rvalid_o, st_ack_o} !== s || err_o !== 1'b0) begin
      n_fail++; $display("FAIL spur_read strobes=%b err=%b required %b/0", {ifill_rvalid_o, ld_rvalid_o, st_ack_o}, err_o, s);
    end
    cyc();
    clr();
    #1;
    n_tests++;
    if (err_o !== 1'b1) begin
      n_fail++; $display("FAIL spur_err err=%b required 1", err_o);
    end
    drive_rsp(1, 2'd0, 3'b000);
    #1;
    s = rsp_q.pop_front();
    n_tests++;
    if ({ifill_rvalid_o, ld_rvalid_o, st_ack_o} !== s) begin
      n_fail++; $display("FAIL spur_ack strobes=%b required %b", {ifill_rvalid_o, ld_rvalid_o, st_ack_o}, s);
    end
    cyc();
    clr();
    repeat (3) cyc();
    n_tests++;
    if (err_o !== 1'b1 || idle_o !== 1'b1) begin
      n_fail++; $display("FAIL spur_sticky err=%b idle=%b required 1/1", err_o, idle_o);
    end
    rst_ni = 0;
    #1;
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL spur_reset err=%b required 0", err_o);
    end
    cyc();
    rst_ni = 1;
    cyc();
  endtask

  task automatic test_drain();
    exp_t e;
    logic [2:0] s;
    ifill_req_i = 1; mem_gnt_i = 1;
    exp_q.push_back('{2'd0, 2'd0, 64'h1000});
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (ifill_gnt_o !== 1'b1 || mem_tid_o !== e.tid) begin
      n_fail++; $display("FAIL drain_pre gnt=%b tid=%0d required 1/%0d", ifill_gnt_o, mem_tid_o, e.tid);
    end
    cyc();
    drain_i = 1; ld_req_i = 1; st_req_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      $display("[TB] drain cycle %0d req=%b", i, mem_req_o);
      n_tests++;
      if ({mem_req_o, ifill_gnt_o, ld_gnt_o, st_gnt_o} !== 4'b0) begin
        n_fail++; $display("FAIL drain_block req/gnt=%b required 0000", {mem_req_o, ifill_gnt_o, ld_gnt_o, st_gnt_o});
      end
      cyc();
    end
    drive_rsp(0, 2'd0, 3'b100);
    #1;
    s = rsp_q.pop_front();
    n_tests++;
    if ({ifill_rvalid_o, ld_rvalid_o, st_ack_o} !== s || idle_o !== 1'b0) begin
      n_fail++; $display("FAIL drain_rsp strobes=%b idle=%b required %b/0", {ifill_rvalid_o, ld_rvalid_o, st_ack_o}, idle_o, s);
    end
    cyc();
    mem_rvalid_i = 0;
    #1;
    n_tests++;
    if (idle_o !== 1'b1) begin
      n_fail++; $display("FAIL drain_idle idle=%b required 1", idle_o);
    end
    drain_i = 0;
    exp_q.push_back('{2'd1, 2'd0, 64'h2000});
    exp_q.push_back('{2'd2, 2'd0, 64'h3000});
    exp_q.push_back('{2'd0, 2'd1, 64'h1000});
    for (int i = 0; i < 3; i++) begin
      #1;
      e = exp_q.pop_front();
      $display("[TB] resume grant type=%0d tid=%0d", mem_type_o, mem_tid_o);
      n_tests++;
      if (!hs_now() || mem_type_o !== e.typ || mem_tid_o !== e.tid || mem_addr_o !== e.addr) begin
        n_fail++; $display("FAIL drain_resume type/tid/addr=%0d/%0d/%h required %0d/%0d/%h",
                           mem_type_o, mem_tid_o, mem_addr_o, e.typ, e.tid, e.addr);
      end
      cyc();
    end
    clr();
  endtask

  function automatic logic hs_now();
    return mem_req_o & mem_gnt_i;
  endfunction

  task automatic test_reset_mid();
    exp_t e;
    st_req_i = 1; mem_gnt_i = 1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{2'd2, 2'd0, 64'h3000});
      #1;
      e = exp_q.pop_front();
      n_tests++;
      if (st_gnt_o !== 1'b1 || mem_type_o !== e.typ) begin
        n_fail++; $display("FAIL mid_store gnt=%b type=%0d required 1/%0d", st_gnt_o, mem_type_o, e.typ);
      end
      cyc();
    end
    ifill_req_i = 1; ld_req_i = 1;
    #1;
    n_tests++;
    if (idle_o !== 1'b0 || mem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy idle=%b req=%b required 0/1", idle_o, mem_req_o);
    end
    rst_ni = 0;
    #1;
    $display("[TB] async reset mid-transaction idle=%b", idle_o);
    n_tests++;
    if (idle_o !== 1'b1 || {mem_req_o, ifill_gnt_o, ld_gnt_o, st_gnt_o} !== 4'b0) begin
      n_fail++; $display("FAIL mid_reset idle=%b req/gnt=%b required 1/0000", idle_o, {mem_req_o, ifill_gnt_o, ld_gnt_o, st_gnt_o});
    end
    clr();
    cyc();
    rst_ni = 1;
    cyc();
    drive_rsp(1, 2'd0, 3'b000);
    #1;
    void'(rsp_q.pop_front());
    n_tests++;
    if (st_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_stale_ack ack=%b required 0", st_ack_o);
    end
    cyc();
    clr();
    #1;
    n_tests++;
    if (err_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_stale_err err=%b required 1", err_o);
    end
  endtask

  initial begin
    clr();
    ifill_addr_i = 64'h1000; ld_addr_i = 64'h2000; st_addr_i = 64'h3000;
    ld_size_i = 2'd3; st_data_i = '0; st_be_i = '0; mem_rdata_i = '0;
    test_reset();
    test_round_robin();
    test_tid_exhaust();
    test_store_limit();
    test_spurious();
    test_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
